// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter family (up/down modulo counter and its
// siblings).
//   dir_t      : count direction encoding, DIR_UP follows the `up` input.
//   CNT_W_MAX  : widest counter any variant supports.
//   clamp_to   : saturating clamp of a value against a terminal count.
// ---------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int CNT_W_MAX = 32;

    // Clamp a candidate value into 0..limit. Operates at the full maximum
    // width so every counter variant can share it.
    function automatic logic [CNT_W_MAX-1:0] clamp_to(
        input logic [CNT_W_MAX-1:0] value,
        input logic [CNT_W_MAX-1:0] limit
    );
        return (value > limit) ? limit : value;
    endfunction

endpackage : counter_pkg

// File: rtl/sticky_flag.sv
// ---------------------------------------------------------------------------
// sticky_flag
// Single-bit set/clear register. Once set it stays set until cleared; a set
// in the same cycle as a clear wins, so an event is never lost to a
// coincident acknowledge.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset (flag -> 0)
//   set   : set request for this edge
//   clr   : clear request for this edge (lower priority than set)
//   flag  : registered flag value
// ---------------------------------------------------------------------------
module sticky_flag (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic flag
);

    logic flag_q;
    logic flag_d;

    always_comb begin
        flag_d = flag_q;
        if (set) begin
            flag_d = 1'b1;
        end else if (clr) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule : sticky_flag

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
// Parametrised up/down modulo counter with synchronous clear/load, wrap or
// saturate at the limits, a one-cycle `wrap` event pulse for cascading and
// sticky overflow/underflow flags.
//
// Parameters
//   WIDTH    : counter width, 2..32
//   MAX_VAL  : terminal count, range is 0..MAX_VAL (1..2**WIDTH-1)
//   SATURATE : 0 = wrap around at a limit, 1 = hold at the limit
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high reset
//   clear      : synchronous clear to 0 (highest priority)
//   load       : synchronous load of load_value (clamped to MAX_VAL)
//   load_value : value to load
//   enable     : count enable (lowest priority)
//   up         : 1 counts up, 0 counts down
//   clr_flags  : clears both sticky flags (an event in the same cycle wins)
//   count      : current count
//   wrap       : one-cycle pulse after any limit event, aligned with the
//                post-event count
//   ovf_flag   : sticky, an up-count was attempted at MAX_VAL
//   udf_flag   : sticky, a down-count was attempted at 0
//
// Cascading: stage N's wrap into stage N+1's enable gives a carry that lags
// by one cycle, because wrap is registered.
// ---------------------------------------------------------------------------
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 255,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf_flag,
    output logic             udf_flag
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    localparam longint unsigned MAX_LEGAL = (64'd1 << WIDTH) - 64'd1;

    generate
        if (WIDTH < 2 || WIDTH > CNT_W_MAX) begin : g_bad_width
            $error("updown_mod_counter: WIDTH must be in 2..%0d", CNT_W_MAX);
        end
        if (MAX_VAL < 1 || longint'(MAX_VAL) > longint'(MAX_LEGAL)) begin : g_bad_max
            $error("updown_mod_counter: MAX_VAL must be in 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    dir_t             dir;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_evt;
    logic             udf_evt;

    assign dir = up ? DIR_UP : DIR_DOWN;

    // Load clamp done at the package's full width so one helper serves every
    // counter size; the result always fits back into WIDTH bits.
    logic [CNT_W_MAX-1:0] load_wide;
    logic [CNT_W_MAX-1:0] load_clamp_wide;

    assign load_wide       = CNT_W_MAX'(load_value);
    assign load_clamp_wide = clamp_to(load_wide, CNT_W_MAX'(MAX_VAL));
    assign load_clamped    = load_clamp_wide[WIDTH-1:0];

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;

        if (clear) begin
            count_d = ZERO_C;
        end else if (load) begin
            count_d = load_clamped;
        end else if (enable) begin
            if (dir == DIR_UP) begin
                // >= rather than == keeps the counter inside 0..MAX_VAL even if
                // it were ever disturbed above the terminal count.
                if (count_q >= MAX_C) begin
                    ovf_evt = 1'b1;
                    wrap_d  = 1'b1;
                    count_d = SATURATE ? MAX_C : ZERO_C;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else begin
                if (count_q == ZERO_C) begin
                    udf_evt = 1'b1;
                    wrap_d  = 1'b1;
                    count_d = SATURATE ? ZERO_C : MAX_C;
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath and event registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= ZERO_C;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky flags, updated at the same edge as wrap so they rise together
    // -----------------------------------------------------------------------
    sticky_flag u_ovf_flag (
        .clk   (clk),
        .reset (reset),
        .set   (ovf_evt),
        .clr   (clr_flags),
        .flag  (ovf_flag)
    );

    sticky_flag u_udf_flag (
        .clk   (clk),
        .reset (reset),
        .set   (udf_evt),
        .clr   (clr_flags),
        .flag  (udf_flag)
    );

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_mod_counter
// Three counter instances share one set of stimulus signals:
//   0 : defaults (8 bit, MAX_VAL 255, wrap)
//   1 : MAX_VAL 9, wrap
//   2 : MAX_VAL 9, saturate
// Each stimulus cycle pushes the expected post-edge outputs of the selected
// instance into a queue; the monitor pops one entry after every rising edge
// and compares.
// ---------------------------------------------------------------------------
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic       enable = 1'b0;
    logic       up = 1'b0;
    logic       clr_flags = 1'b0;

    logic [7:0] cnt_o  [3];
    logic       wrap_o [3];
    logic       ovf_o  [3];
    logic       udf_o  [3];

    always #5 clk = ~clk;

    updown_mod_counter u_def (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .up(up), .clr_flags(clr_flags),
        .count(cnt_o[0]), .wrap(wrap_o[0]), .ovf_flag(ovf_o[0]), .udf_flag(udf_o[0])
    );

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0)) u_mod (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .up(up), .clr_flags(clr_flags),
        .count(cnt_o[1]), .wrap(wrap_o[1]), .ovf_flag(ovf_o[1]), .udf_flag(udf_o[1])
    );

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .up(up), .clr_flags(clr_flags),
        .count(cnt_o[2]), .wrap(wrap_o[2]), .ovf_flag(ovf_o[2]), .udf_flag(udf_o[2])
    );

    typedef struct {
        int         sel;
        logic [7:0] cnt;
        logic       wrap;
        logic       ovf;
        logic       udf;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    task automatic check(input exp_t e);
        n_compared++;
        if (cnt_o[e.sel] !== e.cnt || wrap_o[e.sel] !== e.wrap ||
            ovf_o[e.sel] !== e.ovf || udf_o[e.sel] !== e.udf) begin
            n_mismatched++;
            $display("FAIL %s dut%0d: got cnt=%0d wrap=%b ovf=%b udf=%b, want cnt=%0d wrap=%b ovf=%b udf=%b",
                     e.name, e.sel, cnt_o[e.sel], wrap_o[e.sel], ovf_o[e.sel], udf_o[e.sel],
                     e.cnt, e.wrap, e.ovf, e.udf);
        end else begin
            $display("ok   %s dut%0d: cnt=%0d wrap=%b ovf=%b udf=%b",
                     e.name, e.sel, e.cnt, e.wrap, e.ovf, e.udf);
        end
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check(exp_q.pop_front());
            end
        end
    end

    // One stimulus cycle: drive at the falling edge, expect the result after
    // the following rising edge.
    task automatic cyc(input logic c_clr, input logic c_ld, input logic [7:0] c_lv,
                       input logic c_en, input logic c_up, input logic c_cf,
                       input int sel, input logic [7:0] e_cnt, input logic e_wrap,
                       input logic e_ovf, input logic e_udf, input string nm);
        exp_t e;
        @(negedge clk);
        clear      = c_clr;
        load       = c_ld;
        load_value = c_lv;
        enable     = c_en;
        up         = c_up;
        clr_flags  = c_cf;
        e.sel  = sel;
        e.cnt  = e_cnt;
        e.wrap = e_wrap;
        e.ovf  = e_ovf;
        e.udf  = e_udf;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear = 1'b0; load = 1'b0; load_value = 8'd0;
        enable = 1'b0; up = 1'b0; clr_flags = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        exp_t e;

        // ---- default instance: reset, then 300 up-counts -------------------
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, "reset_state");
        for (int i = 1; i <= 300; i++) begin
            cyc(0, 0, 0, 1, 1, 0, 0, 8'(i % 256), (i == 256), (i >= 256), 0, "up_count");
        end

        // ---- MAX_VAL 9 wrap instance: down-count from 0 --------------------
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 1, 8'd0, 0, 0, 0, "reset_state");
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0, 0, 1, 0, 0, 1, 8'((10 - (i % 10)) % 10), (i % 10 == 1), 0, 1, "down_mod10");
        end
        // Priority: clear beats load beats enable; count was 8.
        cyc(1, 1, 8'd5,   1, 1, 0, 1, 8'd0, 0, 0, 1, "prio_clear");
        cyc(0, 1, 8'd200, 1, 1, 0, 1, 8'd9, 0, 0, 1, "prio_load_clamp");
        cyc(0, 0, 0,      1, 1, 0, 1, 8'd0, 1, 1, 1, "up_wrap_at_9");
        cyc(0, 1, 8'd7,   0, 0, 0, 1, 8'd7, 0, 1, 1, "load_7");
        cyc(0, 0, 0,      0, 1, 0, 1, 8'd7, 0, 1, 1, "idle_hold");

        // Asynchronous reset mid-cycle, checked before the next rising edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        e.sel = 1; e.cnt = 8'd0; e.wrap = 0; e.ovf = 0; e.udf = 0; e.name = "async_reset";
        check(e);
        #2;
        reset = 1'b0;
        cyc(0, 0, 0, 1, 1, 0, 1, 8'd1, 0, 0, 0, "resume_after_reset");

        // ---- MAX_VAL 9 saturate instance ----------------------------------
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 2, 8'd0, 0, 0, 0, "reset_state");
        cyc(0, 1, 8'd8, 0, 0, 0, 2, 8'd8, 0, 0, 0, "sat_load_8");
        cyc(0, 0, 0, 1, 1, 0, 2, 8'd9, 0, 0, 0, "sat_up_1");
        cyc(0, 0, 0, 1, 1, 0, 2, 8'd9, 1, 1, 0, "sat_up_2");
        cyc(0, 0, 0, 1, 1, 0, 2, 8'd9, 1, 1, 0, "sat_up_3");
        cyc(0, 0, 0, 1, 1, 0, 2, 8'd9, 1, 1, 0, "sat_up_4");
        // Flag race: clr_flags with an overflow in the same cycle keeps ovf.
        cyc(0, 0, 0, 1, 1, 1, 2, 8'd9, 1, 1, 0, "flag_race_set_wins");
        cyc(0, 0, 0, 0, 1, 1, 2, 8'd9, 0, 0, 0, "flag_clear");
        cyc(1, 0, 0, 0, 0, 0, 2, 8'd0, 0, 0, 0, "sat_clear");
        cyc(0, 0, 0, 1, 0, 0, 2, 8'd0, 1, 0, 1, "sat_down_at_0");
        cyc(0, 0, 0, 0, 0, 0, 2, 8'd0, 0, 0, 1, "sat_idle");

        // Drain the scoreboard.
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_updown_mod_counter
